// File: rtl/tally_uart_reporter.sv
// Hold-to-confirm reporter: snapshots three tallies, converts them to BCD and sends one ASCII line
// over UART 8N1. Define CHECKSUM_EN to append '*' plus a two-digit hex XOR checksum.
`timescale 1ns/1ps
module tally_uart_reporter #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned COUNT_W     = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               report,
    input  logic [COUNT_W-1:0] bjp_count,
    input  logic [COUNT_W-1:0] cong_count,
    input  logic [COUNT_W-1:0] nota_count,
    output logic               tx,
    output logic               busy,
    output logic               report_conf
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
    localparam int unsigned BIT_W   = $clog2(BIT_CYC);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned POS_W   = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;
`ifdef CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 25;
`else
    localparam int unsigned FRAME_LEN = 22;
`endif
    localparam logic [BIT_W-1:0]  BIT_RELOAD = BIT_W'(BIT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
    localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(COUNT_W - 1);
    localparam logic [4:0]        IDX_LAST   = 5'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        StIdle, StSnap, StConv, StLoad, StStart, StData, StStop
    } state_e;

    state_e                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    conf_q;
    logic                    trigger;
    logic [2:0][COUNT_W-1:0] snap_q, snap_d;
    logic [2:0][15:0]        digits_q, digits_d;
    logic [COUNT_W-1:0]      bin_q, bin_d, bin_src;
    logic [15:0]             bcd_q, bcd_d, bcd_src, bcd_adj, bcd_shift;
    logic [POS_W-1:0]        pos_q, pos_d;
    logic [1:0]              sel_q, sel_d;
    logic [4:0]              idx_q, idx_d;
    logic [7:0]              shift_q, shift_d, load_byte;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    tx_q, tx_d, busy_q, busy_d;

    function automatic logic [7:0] digit_char(input logic [15:0] bcd, input logic [1:0] pos);
        logic [3:0] d;
        d = bcd[4*(3-pos) +: 4];
        return {4'h3, d};
    endfunction

    // Hold detector runs regardless of FSM state
    always_comb begin
        hold_d = '0;
        if (report) hold_d = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_W'(1);
    end

    assign report_conf = (hold_q == HOLD_MAX);
    assign trigger     = report_conf && !conf_q;
    assign tx          = tx_q;
    assign busy        = busy_q;

    // Double dabble: each count restarts from its snapshot with a cleared BCD accumulator
    always_comb begin
        bin_src = (pos_q == '0) ? snap_q[sel_q] : bin_q;
        bcd_src = (pos_q == '0) ? 16'h0 : bcd_q;
        bcd_adj = bcd_src;
        for (int i = 0; i < 4; i++) begin
            if (bcd_src[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_src[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[14:0], bin_src[COUNT_W-1]};
    end

`ifdef CHECKSUM_EN
    logic [7:0] csum;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    // Fixed letters, spaces and '=' fold to 0x72; the twelve 0x30 digit prefixes cancel
    always_comb begin
        csum = 8'h72;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) csum = csum ^ {4'h0, digits_q[i][4*j +: 4]};
        end
    end
`endif

    always_comb begin
        load_byte = 8'h0A;
        case (idx_q)
            5'd0:                       load_byte = 8'h42;
            5'd1, 5'd8, 5'd15:          load_byte = 8'h3D;
            5'd2, 5'd3, 5'd4, 5'd5:     load_byte = digit_char(digits_q[0], 2'(idx_q - 5'd2));
            5'd6, 5'd13:                load_byte = 8'h20;
            5'd7:                       load_byte = 8'h43;
            5'd9, 5'd10, 5'd11, 5'd12:  load_byte = digit_char(digits_q[1], 2'(idx_q - 5'd9));
            5'd14:                      load_byte = 8'h4E;
            5'd16, 5'd17, 5'd18, 5'd19: load_byte = digit_char(digits_q[2], 2'(idx_q - 5'd16));
`ifdef CHECKSUM_EN
            5'd20:                      load_byte = 8'h2A;
            5'd21:                      load_byte = hex_char(csum[7:4]);
            5'd22:                      load_byte = hex_char(csum[3:0]);
            5'd23:                      load_byte = 8'h0D;
`else
            5'd20:                      load_byte = 8'h0D;
`endif
            default:                    load_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        digits_d  = digits_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        pos_d     = pos_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            StIdle: if (trigger) state_d = StSnap;
            StSnap: begin
                snap_d  = {nota_count, cong_count, bjp_count};
                pos_d   = '0;
                sel_d   = 2'd0;
                idx_d   = 5'd0;
                state_d = StConv;
            end
            StConv: begin
                bin_d = bin_src << 1;
                bcd_d = bcd_shift;
                if (pos_q == POS_LAST) begin
                    digits_d[sel_q] = bcd_shift;
                    pos_d           = '0;
                    if (sel_q == 2'd2) state_d = StLoad;
                    else               sel_d   = sel_q + 2'd1;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
            StLoad: begin
                shift_d   = load_byte;
                bit_cnt_d = BIT_RELOAD;
                state_d   = StStart;
            end
            StStart: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end
            StData: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end
            StStop: begin
                if (bit_cnt_q == '0) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StLoad;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so tx never glitches
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            conf_q    <= 1'b0;
            snap_q    <= '0;
            digits_q  <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            pos_q     <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            conf_q    <= report_conf;
            snap_q    <= snap_d;
            digits_q  <= digits_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            pos_q     <= pos_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_tally_uart_reporter.sv
// Bench for tally_uart_reporter: cycle-level frame model, UART decoder, directed and random presses.
`timescale 1ns/1ps
module tb_tally_uart_reporter;

    localparam int unsigned W       = 10;
    localparam int unsigned HOLD    = 8;
    localparam int unsigned BIT_CYC = 4;

    logic         clk, reset, report;
    logic [W-1:0] bjp_count, cong_count, nota_count;
    logic         tx, busy, report_conf;

    tally_uart_reporter #(
        .CLK_FREQ    (40),
        .BAUD        (10),
        .HOLD_CYCLES (HOLD),
        .COUNT_W     (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .report      (report),
        .bjp_count   (bjp_count),
        .cong_count  (cong_count),
        .nota_count  (nota_count),
        .tx          (tx),
        .busy        (busy),
        .report_conf (report_conf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    string        hx = "0123456789ABCDEF";
    byte unsigned frame_q[$];
    byte unsigned tmp_q[$];
    byte unsigned rx_bytes[$];
    bit           plan[$];
    int           m_hold, m_prev_hold;
    bit           m_snap;

    function automatic void push_num(input int v);
        frame_q.push_back(8'h30 + 8'((v / 1000) % 10));
        frame_q.push_back(8'h30 + 8'((v / 100) % 10));
        frame_q.push_back(8'h30 + 8'((v / 10) % 10));
        frame_q.push_back(8'h30 + 8'(v % 10));
    endfunction

    function automatic void make_frame(input int b, input int c, input int n);
        byte unsigned x;
        frame_q.delete();
        frame_q.push_back(8'h42); frame_q.push_back(8'h3D); push_num(b); frame_q.push_back(8'h20);
        frame_q.push_back(8'h43); frame_q.push_back(8'h3D); push_num(c); frame_q.push_back(8'h20);
        frame_q.push_back(8'h4E); frame_q.push_back(8'h3D); push_num(n);
`ifdef CHECKSUM_EN
        x = 0;
        for (int i = 0; i < 20; i++) x = x ^ frame_q[i];
        frame_q.push_back(8'h2A);
        frame_q.push_back(hx[x >> 4]);
        frame_q.push_back(hx[x & 8'h0F]);
`endif
        frame_q.push_back(8'h0D);
        frame_q.push_back(8'h0A);
    endfunction

    function automatic void model_reset();
        m_hold = 0; m_prev_hold = 0; m_snap = 0;
        plan.delete();
    endfunction

    // Advances the model across one rising edge; plan holds tx for each remaining busy cycle
    function automatic void model_step();
        if (m_snap) begin
            m_snap = 0;
            make_frame(int'(bjp_count), int'(cong_count), int'(nota_count));
            plan.delete();
            for (int i = 0; i < 3 * W; i++) plan.push_back(1'b1);
            foreach (frame_q[k]) begin
                plan.push_back(1'b1);
                for (int i = 0; i < BIT_CYC; i++) plan.push_back(1'b0);
                for (int b = 0; b < 8; b++)
                    for (int i = 0; i < BIT_CYC; i++) plan.push_back(frame_q[k][b]);
                for (int i = 0; i < BIT_CYC; i++) plan.push_back(1'b1);
            end
        end else if (plan.size() > 0) begin
            void'(plan.pop_front());
        end else if (m_hold == HOLD && m_prev_hold != HOLD) begin
            m_snap = 1;
        end
        m_prev_hold = m_hold;
        m_hold = report ? ((m_hold < HOLD) ? m_hold + 1 : HOLD) : 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) model_reset(); else model_step();
            @(negedge clk);
            if (!reset) model_reset();
            check("cyc_tx", tx, (plan.size() > 0) ? int'(plan[0]) : 1);
            check("cyc_busy", busy, (m_snap || plan.size() > 0) ? 1 : 0);
            check("cyc_conf", report_conf, (m_hold == HOLD) ? 1 : 0);
        end
    end

    // ---------------- UART decoder and monitors ----------------
    bit conf_seen;
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && reset) begin
                repeat (5) @(negedge clk);
                b[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BIT_CYC) @(negedge clk);
                rx_bytes.push_back(b);
            end
        end
    end

    always @(negedge clk) if (report_conf) conf_seen = 1'b1;

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input int n);
        report = 1'b1;
        tick(n);
        report = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        check(name, busy, 0);
    endtask

    task automatic wait_busy(input string name, input int budget);
        int k = 0;
        while (!busy && k < budget) begin tick(); k++; end
        check(name, busy, 1);
    endtask

    task automatic cmp_tmp(input string name, input string exp);
        check({name, "_len"}, tmp_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < tmp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), tmp_q[i], exp[i]);
    endtask

    task automatic set_counts(input int b, input int c, input int n);
        bjp_count = W'(b); cong_count = W'(c); nota_count = W'(n);
    endtask

`ifdef CHECKSUM_EN
    string frame_a = "B=0005 C=0123 N=1023*77\015\012";
`else
    string frame_a = "B=0005 C=0123 N=1023\015\012";
`endif

    initial begin
        int k;
        reset = 1'b0; report = 1'b0;
        set_counts(0, 0, 0);

        // Pin the model against hand-computed frames
        make_frame(5, 123, 1023); tmp_q = frame_q; cmp_tmp("model_a", frame_a);
`ifdef CHECKSUM_EN
        make_frame(0, 0, 0); tmp_q = frame_q; cmp_tmp("model_z", "B=0000 C=0000 N=0000*72\015\012");
`endif

        // Reset and idle
        tick(3);
        check("rst_tx", tx, 1); check("rst_busy", busy, 0); check("rst_conf", report_conf, 0);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx != 1'b1 || busy != 1'b0 || report_conf != 1'b0) begin
                check("idle_outputs", {tx, busy, report_conf}, 3'b100);
            end
        end
        check("idle_end", {tx, busy, report_conf}, 3'b100);

        // One frame from a 20-cycle hold
        set_counts(5, 123, 1023);
        rx_bytes.delete();
        report = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 7) check("conf_at7", report_conf, 0);
            if (i == 8) begin check("conf_at8", report_conf, 1); check("busy_at8", busy, 0); end
            if (i == 9) check("busy_at9", busy, 1);
        end
        check("conf_at20", report_conf, 1);
        report = 1'b0;
        tick();
        check("conf_release", report_conf, 0);
        wait_idle("t2_idle", 2000);
        tick(10);
        tmp_q = rx_bytes; cmp_tmp("t2_frame", frame_a);

        // Short holds never fire
        conf_seen = 1'b0; rx_bytes.delete();
        repeat (3) begin press(7); tick(3); end
        tick(20);
        check("t3_conf_seen", conf_seen, 0);
        check("t3_rx_count", rx_bytes.size(), 0);
        check("t3_busy", busy, 0);

        // Snapshot isolation and dropped second trigger
        set_counts(5, 123, 1023);
        rx_bytes.delete();
        report = 1'b1;
        wait_busy("t4_trig", 40);
        report = 1'b0;
        tick(3);
        bjp_count = W'(6);
        tick(100);
        press(20);
        wait_idle("t4_idle", 2000);
        tick(60);
        check("t4_busy_after", busy, 0);
        tmp_q = rx_bytes; cmp_tmp("t4_frame", frame_a);

        // Reset during the 10th byte's data bits
        set_counts(5, 123, 1023);
        report = 1'b1;
        wait_busy("t5_trig", 40);
        report = 1'b0;
        tick(410);
        check("t5_tx_before", tx, 0);
        reset = 1'b0;
        #1;
        check("t5_tx_reset", tx, 1);
        check("t5_busy_reset", busy, 0);
        tick(5);
        reset = 1'b1;
        tick(50);
        check("t5_idle", {tx, busy}, 2'b10);
        rx_bytes.delete();
        press(20);
        wait_idle("t5_idle2", 2000);
        tick(10);
        tmp_q = rx_bytes; cmp_tmp("t5_frame", frame_a);

`ifdef CHECKSUM_EN
        set_counts(0, 0, 0);
        rx_bytes.delete();
        press(20);
        wait_idle("t6_idle", 2000);
        tick(10);
        tmp_q = rx_bytes; cmp_tmp("t6_frame", "B=0000 C=0000 N=0000*72\015\012");
`endif

        // Random presses and tally changes, checked cycle by cycle against the model
        for (int it = 0; it < 14; it++) begin
            k = $urandom_range(1, 14);
            report = 1'b1;
            for (int d = 0; d < k; d++) begin
                if ($urandom_range(0, 3) == 0)
                    set_counts($urandom_range(0, 1023), $urandom_range(0, 1023),
                               $urandom_range(0, 1023));
                tick();
            end
            report = 1'b0;
            tick($urandom_range(1, 6));
            if ($urandom_range(0, 2) == 0) tick(950);
        end
        wait_idle("rand_idle", 2000);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
